// File: rtl/opr_pkg.sv
// Shared constants and FSM state type for the operation scheduler.
package opr_pkg;
  localparam int OPR_DEPTH  = 1024;
  localparam int OPR_ADDR_W = 10;
  localparam int OPR_PHASES = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    DONE = 3'd4
  } opr_state_t;
endpackage

// File: rtl/opr_sched_if.sv
// Host / memory / operation-stage bundle of the scheduler.
interface opr_sched_if
  import opr_pkg::*;
#(
  parameter int ADDR_W = OPR_ADDR_W,
  parameter int PHASES = OPR_PHASES
);
  logic              start;
  logic [ADDR_W:0]   num_lines;
  logic              abort;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic              stall;
  logic [PHASES-1:0] phase_en;
  logic [ADDR_W:0]   line_cnt;
  logic              busy;
  logic              done;

  // Host / environment side.
  modport master (
    output start, num_lines, abort, mem_rvalid, stall,
    input  mem_rd, mem_addr, phase_en, line_cnt, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, num_lines, abort, mem_rvalid, stall,
    output mem_rd, mem_addr, phase_en, line_cnt, busy, done
  );
endinterface

// File: rtl/opr_phase_seq.sv
// One-hot phase shifter: loaded with phase 0, walks left while not stalled,
// and shifts itself out to all-zero after the last phase.
module opr_phase_seq #(
  parameter int PHASES = 5
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              load,
  input  logic              stall,
  input  logic              clear,
  output logic [PHASES-1:0] phase_en,
  output logic              last
);
  logic [PHASES-1:0] ph_q;

  // Shift register; clear beats load so an abort on the rvalid cycle wins.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)       ph_q <= '0;
    else if (clear)  ph_q <= '0;
    else if (load)   ph_q <= PHASES'(1);
    else if (!stall) ph_q <= ph_q << 1;
  end

  // Last phase is retiring this cycle.
  always_comb begin
    phase_en = ph_q;
    last     = ph_q[PHASES-1] & ~stall;
  end
endmodule

// File: rtl/opr_sched.sv
// Line-by-line scheduler: fetch a trace line, then step it through the
// operation phases, repeat until the latched line count is reached.
module opr_sched
  import opr_pkg::*;
#(
  parameter int DEPTH  = OPR_DEPTH,
  parameter int ADDR_W = OPR_ADDR_W,
  parameter int PHASES = OPR_PHASES
) (
  input logic        clk,
  input logic        rstb,
  opr_sched_if.slave bus
);
  opr_state_t        state, state_nx;
  logic [ADDR_W:0]   lines_q;
  logic [ADDR_W:0]   line_cnt_q;
  logic [ADDR_W:0]   line_inc;
  logic [ADDR_W:0]   num_clamp;
  logic [PHASES-1:0] phase_en;
  logic              last;
  logic              ph_load;

  assign line_inc  = line_cnt_q + (ADDR_W+1)'(1);
  assign num_clamp = (bus.num_lines > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH)
                                                          : bus.num_lines;
  assign ph_load   = (state == WAIT) && bus.mem_rvalid;

  opr_phase_seq #(.PHASES(PHASES)) u_seq (
    .clk      (clk),
    .rstb     (rstb),
    .load     (ph_load),
    .stall    (bus.stall),
    .clear    (bus.abort),
    .phase_en (phase_en),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = (bus.num_lines == '0) ? DONE : REQ;
      REQ:  state_nx = WAIT;
      WAIT: if (bus.mem_rvalid) state_nx = EXEC;
      EXEC: if (last) state_nx = (line_inc == lines_q) ? DONE : REQ;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort && state != IDLE) state_nx = IDLE;
  end

  // Run length latch and completed-line counter.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lines_q    <= '0;
      line_cnt_q <= '0;
    end else if (state == IDLE && bus.start) begin
      lines_q    <= num_clamp;
      line_cnt_q <= '0;
    end else if (state == EXEC && last && !bus.abort) begin
      line_cnt_q <= line_inc;
    end
  end

  // Outputs decoded from registered state and counters only.
  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.phase_en = phase_en;
    bus.line_cnt = line_cnt_q;
    unique case (state)
      REQ: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = line_cnt_q[ADDR_W-1:0];
        bus.busy     = 1'b1;
      end
      WAIT: bus.busy = 1'b1;
      EXEC: bus.busy = 1'b1;
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_opr_sched.sv
// Scheduler bench: each run is planned up front as a per-cycle table of
// stimulus and expected outputs derived from the line cost rules
// (REQ + memory latency + five phases + stall cycles), then replayed.
module tb_opr_sched;
  logic clk = 1'b0;
  logic rstb;

  opr_sched_if bus ();

  opr_sched dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic [10:0] num;
    logic        abort;
    logic        rvalid;
    logic        stall;
    logic        rd;
    logic [9:0]  addr;
    logic [4:0]  ph;
    logic [10:0] lc;
    logic        busy;
    logic        done;
  } cyc_t;

  cyc_t tl[$];
  int   m_lc;
  bit   noise;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic nz();
    return noise ? 1'($urandom) : 1'b0;
  endfunction

  function automatic logic [10:0] nm();
    return noise ? 11'($urandom) : 11'd0;
  endfunction

  function automatic void push(logic st, logic [10:0] num, logic ab, logic rv, logic sl,
                               logic rd, logic [9:0] ad, logic [4:0] ph, logic by, logic dn);
    cyc_t c;
    c.start = st; c.num = num; c.abort = ab; c.rvalid = rv; c.stall = sl;
    c.rd = rd; c.addr = ad; c.ph = ph; c.lc = 11'(m_lc); c.busy = by; c.done = dn;
    tl.push_back(c);
  endfunction

  // Build one run. st_ph >= 0 puts st_hi stall cycles on that phase of line 0
  // only; otherwise each line gets a random stall phase and length.
  function automatic void plan(int nl, int ab_line, int ab_ph, int lat_lo, int lat_hi,
                               int st_ph, int st_lo, int st_hi);
    int n, lat, sp, sl;
    logic [10:0] nlv;
    n   = (nl > 1024) ? 1024 : nl;
    nlv = 11'(nl);
    push(1'b1, nlv, 1'b0, nz(), nz(), 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
    m_lc = 0;
    for (int i = 0; i < n; i++) begin
      lat = $urandom_range(lat_hi, lat_lo);
      if (st_ph >= 0) begin
        sp = st_ph;
        sl = (i == 0) ? st_hi : 0;
      end else begin
        sp = $urandom_range(4, 0);
        sl = $urandom_range(st_hi, st_lo);
      end
      push(nz(), nm(), 1'b0, nz(), nz(), 1'b1, 10'(i), 5'd0, 1'b1, 1'b0);
      for (int w = 1; w <= lat; w++)
        push(nz(), nm(), 1'b0, (w == lat), nz(), 1'b0, 10'd0, 5'd0, 1'b1, 1'b0);
      for (int p = 0; p < 5; p++) begin
        if (p == sp)
          for (int s = 0; s < sl; s++)
            push(nz(), nm(), 1'b0, nz(), 1'b1, 1'b0, 10'd0, 5'(1 << p), 1'b1, 1'b0);
        if (i == ab_line && p == ab_ph) begin
          push(nz(), nm(), 1'b1, nz(), 1'b0, 1'b0, 10'd0, 5'(1 << p), 1'b1, 1'b0);
          push(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
          return;
        end
        push(nz(), nm(), 1'b0, nz(), 1'b0, 1'b0, 10'd0, 5'(1 << p), 1'b1, 1'b0);
      end
      m_lc = i + 1;
    end
    push(nz(), nm(), 1'b0, nz(), nz(), 1'b0, 10'd0, 5'd0, 1'b0, 1'b1);
    push(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0, 1'b0);
  endfunction

  // Replay up to lim planned cycles; inputs at posedge+1, outputs at negedge.
  task automatic exec(input int lim);
    cyc_t c;
    int   k = 0;
    while (tl.size() > 0 && k < lim) begin
      c = tl.pop_front();
      bus.start      = c.start;
      bus.num_lines  = c.num;
      bus.abort      = c.abort;
      bus.mem_rvalid = c.rvalid;
      bus.stall      = c.stall;
      @(negedge clk);
      chk("mem_rd",   32'(bus.mem_rd),   32'(c.rd));
      chk("mem_addr", 32'(bus.mem_addr), 32'(c.addr));
      chk("phase_en", 32'(bus.phase_en), 32'(c.ph));
      chk("line_cnt", 32'(bus.line_cnt), 32'(c.lc));
      chk("busy",     32'(bus.busy),     32'(c.busy));
      chk("done",     32'(bus.done),     32'(c.done));
      @(posedge clk);
      #1;
      k++;
    end
    tl.delete();
  endtask

  task automatic idle_in();
    bus.start = 1'b0; bus.num_lines = '0; bus.abort = 1'b0;
    bus.mem_rvalid = 1'b0; bus.stall = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},    32'(bus.mem_rd),   32'd0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
    chk({tag, "_phase"}, 32'(bus.phase_en), 32'd0);
    chk({tag, "_lcnt"},  32'(bus.line_cnt), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),     32'd0);
    chk({tag, "_done"},  32'(bus.done),     32'd0);
  endtask

  initial begin
    int nl, ab;
    rstb = 1'b0;
    idle_in();
    m_lc = 0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // num_lines = 0 straight after reset: DONE next cycle, no read.
    noise = 1'b0;
    plan(0, -1, 0, 1, 1, -1, 0, 0);       exec(100);
    // Single line, rvalid one cycle after mem_rd, no stall.
    plan(1, -1, 0, 1, 1, -1, 0, 0);       exec(100);
    // Two lines, 3 stall cycles on phase 2 of the first line.
    plan(2, -1, 0, 1, 1, 2, 3, 3);        exec(100);
    // Five-cycle memory latency, spurious rvalid/start/stall noise elsewhere.
    noise = 1'b1;
    plan(2, -1, 0, 5, 5, -1, 0, 0);       exec(100);
    // Abort during EXEC of the third line.
    plan(5, 2, 2, 1, 3, -1, 0, 2);        exec(200);
    // Oversized run clamps to the full image.
    plan(1500, -1, 0, 1, 2, -1, 0, 1);    exec(20000);
    // Random runs, some aborted (including on the last-phase cycle).
    for (int r = 0; r < 10; r++) begin
      nl = $urandom_range(20, 1);
      ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(nl - 1, 0)) : -1;
      plan(nl, ab, $urandom_range(4, 0), 1, 4, -1, 0, 3);
      exec(2000);
    end

    // Asynchronous reset mid-run clears everything without a clock edge.
    plan(6, -1, 0, 1, 2, -1, 0, 2);
    exec(15);
    idle_in();
    #2;
    rstb = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rstb = 1'b1;
    m_lc = 0;
    @(posedge clk);
    #1;
    plan(2, -1, 0, 1, 2, -1, 0, 1);       exec(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
